mii_tx_arbiter: RTL

Two-requester frame-level arbiter and sequencer for the MII TX path in the PHY clock domain. It sits between two nibble-stream sources and the MII TX bus: it grants the bus one whole frame at a time in round-robin order, forwards the granted stream with one cycle of registration, and enforces the inter-frame gap. It also aborts frames that never start or that exceed the maximum length.

---
 rtl/mii_tx_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mii_tx_arbiter.sv
// Round-robin frame arbiter for two MII TX nibble sources: grants whole frames,
// forwards the winner with one register stage, and enforces IFG, start timeout and length limit.
module mii_tx_arbiter #(
    parameter int IFG_NIBBLES       = 24,
    parameter int MAX_FRAME_NIBBLES = 3044,
    parameter int START_TIMEOUT     = 16,
    parameter int CNT_W             = 12
) (
    input  logic       TX_CLK,
    input  logic       RST_PHY,
    input  logic [1:0] REQ,
    input  logic [1:0] REQ_TX_EN,
    input  logic [7:0] REQ_TXD,
    output logic [1:0] GNT,
    output logic       MII_TX_EN,
    output logic [3:0] MII_TXD,
    output logic       MII_TX_ER,
    output logic       BUSY,
    output logic       START_TO,
    output logic       OVERSIZE
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        XMIT,
        IFG
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_FRAME_NIBBLES);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             tx_en_p1, tx_en_d;
    logic [3:0]       txd_p1, txd_d;
    logic             tx_er_p1, tx_er_d;
    logic             start_to_q, start_to_d;
    logic             oversize_q, oversize_d;

    logic [1:0] elig;
    logic       win;
    logic       g_tx_en;
    logic [3:0] g_txd;

    // A requester still holding TX_EN (e.g. after an abort) is never eligible.
    assign elig    = REQ & ~REQ_TX_EN;
    assign win     = (elig == 2'b10) | ((elig == 2'b11) & ~last_q);
    assign g_tx_en = gnt_q[1] ? REQ_TX_EN[1] : REQ_TX_EN[0];
    assign g_txd   = gnt_q[1] ? REQ_TXD[7:4] : REQ_TXD[3:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        tx_en_d    = 1'b0;
        txd_d      = 4'h0;
        tx_er_d    = 1'b0;
        start_to_d = 1'b0;
        oversize_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    cnt_d   = '0;
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (g_tx_en) begin
                    tx_en_d = 1'b1;
                    txd_d   = g_txd;
                    cnt_d   = CNT_ONE;
                    state_d = XMIT;
                end else if (cnt_q == TO_LAST) begin
                    gnt_d      = 2'b00;
                    start_to_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = IFG;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            XMIT: begin
                if (!g_tx_en) begin
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                    state_d = IFG;
                end else if (cnt_q == MAX_LAST) begin
                    // Abort cycle: keep TX_EN up for one cycle with TX_ER.
                    tx_en_d    = 1'b1;
                    txd_d      = g_txd;
                    tx_er_d    = 1'b1;
                    oversize_d = 1'b1;
                    gnt_d      = 2'b00;
                    cnt_d      = '0;
                    state_d    = IFG;
                end else begin
                    tx_en_d = 1'b1;
                    txd_d   = g_txd;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: registered MII outputs and control state.
    always_ff @(posedge TX_CLK) begin
        if (RST_PHY) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt_q      <= 2'b00;
            tx_en_p1   <= 1'b0;
            txd_p1     <= 4'h0;
            tx_er_p1   <= 1'b0;
            start_to_q <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            tx_en_p1   <= tx_en_d;
            txd_p1     <= txd_d;
            tx_er_p1   <= tx_er_d;
            start_to_q <= start_to_d;
            oversize_q <= oversize_d;
        end
    end

    assign GNT       = gnt_q;
    assign MII_TX_EN = tx_en_p1;
    assign MII_TXD   = txd_p1;
    assign MII_TX_ER = tx_er_p1;
    assign BUSY      = (state_q != IDLE);
    assign START_TO  = start_to_q;
    assign OVERSIZE  = oversize_q;

endmodule
